// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles big-endian words, writes them to
// instruction memory by word index and holds the CPU in reset until the load verifies.
module imem_loader #(
    parameter int DEPTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    // Wide enough to hold N itself, so the post-increment after the last word fits.
    localparam int WCW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t         state_q,    state_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [WCW-1:0] last_idx_q, last_idx_d;
    logic [7:0]     len_hi_q,   len_hi_d;
    logic [7:0]     xor_q,      xor_d;
    logic [23:0]    asm_q,      asm_d;
    logic           mem_we_q,   mem_we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wd_q,   mem_wd_d;

    logic           xfer_s;
    logic           restart_s;
    logic [15:0]    len_s;
    logic           len_over_s;
    logic           len_zero_s;
    logic           word_end_s;
    logic           last_word_s;
    logic           csum_ok_s;

    assign xfer_s      = in_valid && in_ready;
    assign restart_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                   (state_q == S_ERROR));
    assign len_s       = {len_hi_q, in_data};
    assign len_over_s  = (len_s > 16'(DEPTH));
    assign len_zero_s  = (len_s == 16'd0);
    assign word_end_s  = (byte_cnt_q == 2'd3);
    assign last_word_s = (word_cnt_q == last_idx_q);
    assign csum_ok_s   = (in_data == xor_q);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    state_d = S_LEN_LO;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (!xfer_s) begin
                    state_d = S_LEN_LO;
                end else if (len_over_s) begin
                    state_d = S_ERROR;
                end else if (len_zero_s) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer_s && word_end_s && last_word_s) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (!xfer_s) begin
                    state_d = S_CSUM;
                end else if (csum_ok_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        in_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath next state: counters, checksum, word assembly and write port
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        last_idx_d = last_idx_q;
        len_hi_d   = len_hi_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        if (restart_s) begin
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
            xor_d      = 8'd0;
            asm_d      = 24'd0;
        end else if (xfer_s) begin
            case (state_q)
                S_LEN_HI: begin
                    len_hi_d = in_data;
                    xor_d    = xor_q ^ in_data;
                end
                S_LEN_LO: begin
                    // Only meaningful when 1 <= N <= DEPTH; otherwise never consulted.
                    last_idx_d = len_s[WCW-1:0] - WCW'(1'b1);
                    xor_d      = xor_q ^ in_data;
                end
                S_DATA: begin
                    xor_d      = xor_q ^ in_data;
                    asm_d      = {asm_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (word_end_s) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = 32'(word_cnt_q);
                        mem_wd_d   = {asm_q, in_data};
                        word_cnt_d = word_cnt_q + WCW'(1'b1);
                    end else begin
                        mem_we_d = 1'b0;
                    end
                end
                default: begin
                    xor_d = xor_q;
                end
            endcase
        end else begin
            mem_we_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            last_idx_q <= '0;
            len_hi_q   <= 8'd0;
            xor_q      <= 8'd0;
            asm_q      <= 24'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_wd_q   <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            last_idx_q <= last_idx_d;
            len_hi_q   <= len_hi_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames checked against a
// frame-level model (expected writes, timing and final status from the byte list).
module tb_imem_loader;

    localparam int DEPTH = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  frm[$];
    int          acc[0:63];
    int          cap_cyc[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_wd[$];
    logic        rand_start = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance past the edge, then observe at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (mem_we === 1'b1) begin
            cap_cyc.push_back(cyc);
            cap_addr.push_back(mem_addr);
            cap_wd.push_back(mem_wd);
        end
    endtask

    function automatic int frame_words();
        int n;
        n = int'({frm[0], frm[1]});
        return n;
    endfunction

    function automatic int frame_nbytes();
        int n;
        n = frame_words();
        if (n > DEPTH) return 2;
        return 4 * n + 3;
    endfunction

    task automatic do_start();
        cap_cyc.delete();
        cap_addr.delete();
        cap_wd.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ready", 32'(in_ready), 32'd1);
        check_eq("start_done", 32'(done), 32'd0);
        check_eq("start_error", 32'(error), 32'd0);
        check_eq("start_cpurst", 32'(cpu_reset), 32'd1);
    endtask

    task automatic send_bytes(input int nb, input int max_gap);
        for (int i = 0; i < nb; i++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(0, max_gap);
                for (int j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    start    = rand_start ? 1'($urandom) : 1'b0;
                    tick();
                end
            end
            check_eq("byte_ready", 32'(in_ready), 32'd1);
            start    = rand_start ? 1'($urandom) : 1'b0;
            in_valid = 1'b1;
            in_data  = frm[i];
            tick();
            acc[i]   = cyc;
            in_valid = 1'b0;
        end
        start = 1'b0;
    endtask

    // Frame-level model: status right after the last accepted byte, then the write log.
    task automatic check_frame();
        int         n;
        int         nb;
        int         nw;
        logic [7:0] x;
        logic       ok;
        n  = frame_words();
        nb = frame_nbytes();
        x  = 8'd0;
        if (n > DEPTH) begin
            nw = 0;
            ok = 1'b0;
        end else begin
            nw = n;
            for (int i = 0; i < nb - 1; i++) x = x ^ frm[i];
            ok = (x == frm[nb-1]);
        end
        check_eq("end_done", 32'(done), 32'(ok));
        check_eq("end_error", 32'(error), 32'(!ok));
        check_eq("end_cpurst", 32'(cpu_reset), 32'(!ok));
        check_eq("end_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("hold_done", 32'(done), 32'(ok));
        check_eq("nwrites", 32'(cap_cyc.size()), 32'(nw));
        for (int k = 0; k < nw && k < cap_cyc.size(); k++) begin
            int b;
            b = 2 + 4 * k;
            check_eq("wr_cycle", 32'(cap_cyc[k]), 32'(acc[b+3]));
            check_eq("wr_addr", cap_addr[k], 32'(k));
            check_eq("wr_data", cap_wd[k], {frm[b], frm[b+1], frm[b+2], frm[b+3]});
        end
        if (nw > 0) begin
            int b;
            b = 2 + 4 * (nw - 1);
            check_eq("hold_addr", mem_addr, 32'(nw - 1));
            check_eq("hold_wd", mem_wd, {frm[b], frm[b+1], frm[b+2], frm[b+3]});
        end
    endtask

    task automatic run_frame(input int max_gap);
        do_start();
        send_bytes(frame_nbytes(), max_gap);
        check_frame();
    endtask

    task automatic load_two_word(input logic [7:0] csum);
        frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                8'h9A, 8'hBC, 8'hDE, 8'hF0, csum};
    endtask

    task automatic make_random_frame();
        int         n;
        logic [7:0] x;
        frm.delete();
        n = $urandom_range(0, DEPTH + 3);
        if (n > DEPTH && $urandom_range(0, 1) == 1) begin
            frm.push_back(8'($urandom_range(1, 255)));
            frm.push_back(8'($urandom));
        end else begin
            frm.push_back(8'(n >> 8));
            frm.push_back(8'(n));
        end
        if (frame_words() <= DEPTH) begin
            x = frm[0] ^ frm[1];
            for (int i = 0; i < 4 * n; i++) begin
                frm.push_back(8'($urandom));
                x = x ^ frm[frm.size() - 1];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            frm.push_back(x);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        // Reset held for two edges
        tick();
        tick();
        check_eq("rst_cpurst", 32'(cpu_reset), 32'd1);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wd", mem_wd, 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        tick();
        check_eq("idle_ready", 32'(in_ready), 32'd0);

        // Two-word load, back to back
        load_two_word(8'h02);
        run_frame(0);
        check_eq("w0_const", (cap_wd.size() > 0) ? cap_wd[0] : 32'hxxxxxxxx, 32'h12345678);
        check_eq("w1_const", (cap_wd.size() > 1) ? cap_wd[1] : 32'hxxxxxxxx, 32'h9ABCDEF0);

        // Bad checksum, then recovery with the correct frame
        load_two_word(8'h03);
        run_frame(0);
        check_eq("bad_error", 32'(error), 32'd1);
        load_two_word(8'h02);
        run_frame(0);
        check_eq("recover_done", 32'(done), 32'd1);

        // Over-length N = DEPTH + 1
        frm = '{8'h00, 8'h0B};
        run_frame(0);
        check_eq("over_error", 32'(error), 32'd1);

        // Exact DEPTH boundary and zero length
        frm.delete();
        frm.push_back(8'h00);
        frm.push_back(8'(DEPTH));
        begin
            logic [7:0] x;
            x = 8'(DEPTH);
            for (int i = 0; i < 4 * DEPTH; i++) begin
                frm.push_back(8'($urandom));
                x = x ^ frm[frm.size() - 1];
            end
            frm.push_back(x);
        end
        run_frame(2);
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame(3);

        // Two-word frame with random idle gaps and ignored start pulses
        rand_start = 1'b1;
        load_two_word(8'h02);
        run_frame(5);
        rand_start = 1'b0;

        // Reset after the 7th data byte
        load_two_word(8'h02);
        do_start();
        send_bytes(9, 0);
        reset = 1'b0;
        tick();
        check_eq("mid_cpurst", 32'(cpu_reset), 32'd1);
        check_eq("mid_ready", 32'(in_ready), 32'd0);
        check_eq("mid_we", 32'(mem_we), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("mid_nwrites", 32'(cap_cyc.size()), 32'd1);
        check_eq("mid_idle", 32'(in_ready), 32'd0);
        run_frame(0);

        // Randomized frames
        for (int t = 0; t < 25; t++) begin
            rand_start = ($urandom_range(0, 1) == 1);
            make_random_frame();
            run_frame($urandom_range(0, 3));
        end
        rand_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
